// File: rtl/miller_decode.sv
`default_nettype none
// ==========================================================================
// miller_decode : modified-Miller (ISO 14443-A PCD) pause-to-bit decoder
// Rev 1.0
// ==========================================================================
module miller_decode #(
  parameter int Z_WIN_END = 47,
  parameter int X_WIN_END = 111
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_n_synchronised,
  output logic soc,
  output logic data,
  output logic data_valid,
  output logic eoc,
  output logic error,
  output logic last_rx_bit
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FRAME = 1'b1;

  localparam logic [6:0] c_z_end    = 7'(Z_WIN_END);
  localparam logic [6:0] c_x_end    = 7'(X_WIN_END);
  localparam logic [6:0] c_win_last = 7'd127;
  // The rise cycle itself occupies the resync count, so the register takes resync+1.
  localparam logic [6:0] c_z_next   = 7'd17;
  localparam logic [6:0] c_x_next   = 7'd81;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic       r_pause_q;
  logic       w_rise;
  logic [6:0] r_count;
  logic       r_win_rise;
  logic       r_win_x;
  logic       r_soc_win;
  logic       r_prev;
  logic       r_pend_valid;
  logic       r_pend_bit;
  logic       w_win_end;
  logic       w_rise_err;
  logic       w_end_err;
  logic       w_end_eoc;
  logic       w_end_data;
  logic       w_end_sym;
  logic       w_abort;
  logic       w_soc_nxt;
  logic       w_dv_nxt;
  logic       w_data_nxt;
  logic       w_eoc_nxt;
  logic       w_err_nxt;

  assign w_rise    = pause_n_synchronised & ~r_pause_q;
  assign w_win_end = (r_state == S_FRAME) && (r_count == c_win_last);
  assign w_abort   = w_rise_err | w_end_err | w_end_eoc;

  // Window classification; a rise on the window-end cycle belongs to the next window.
  always_comb begin
    w_rise_err = 1'b0;
    w_end_err  = 1'b0;
    w_end_eoc  = 1'b0;
    w_end_data = 1'b0;
    w_end_sym  = 1'b0;
    if (r_state == S_FRAME) begin
      if (w_win_end) begin
        if (!r_soc_win) begin
          if (r_win_rise && r_win_x) begin
            w_end_data = 1'b1;
            w_end_sym  = 1'b1;
          end else if (r_win_rise) begin
            if (r_prev) w_end_err  = 1'b1;
            else        w_end_data = 1'b1;
          end else begin
            if (r_prev) w_end_data = 1'b1;
            else        w_end_eoc  = 1'b1;
          end
        end
      end else if (w_rise && (r_win_rise || (r_count > c_x_end))) begin
        w_rise_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_rise)  w_state_nxt = S_FRAME;
      S_FRAME: if (w_abort) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_soc_nxt  = (r_state == S_IDLE) && w_rise;
    w_dv_nxt   = w_end_data && r_pend_valid;
    w_data_nxt = w_dv_nxt && r_pend_bit;
    w_eoc_nxt  = w_end_eoc;
    w_err_nxt  = w_end_err || w_rise_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Idle line is high; starting the copy high avoids a false SOC out of reset.
      r_pause_q    <= 1'b1;
      r_count      <= '0;
      r_win_rise   <= 1'b0;
      r_win_x      <= 1'b0;
      r_soc_win    <= 1'b0;
      r_prev       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_bit   <= 1'b0;
    end else begin
      r_pause_q <= pause_n_synchronised;
      if (r_state == S_IDLE) begin
        if (w_rise) begin
          r_count      <= c_z_next;
          r_win_rise   <= 1'b1;
          r_win_x      <= 1'b0;
          r_soc_win    <= 1'b1;
          r_prev       <= 1'b0;
          r_pend_valid <= 1'b0;
        end
      end else if (w_abort) begin
        r_pend_valid <= 1'b0;
      end else if (w_win_end) begin
        r_soc_win  <= 1'b0;
        r_win_x    <= 1'b0;
        r_win_rise <= w_rise;
        r_count    <= w_rise ? c_z_next : 7'd0;
        if (w_end_data) begin
          r_pend_valid <= 1'b1;
          r_pend_bit   <= w_end_sym;
          r_prev       <= w_end_sym;
        end
      end else if (w_rise) begin
        r_win_rise <= 1'b1;
        r_win_x    <= (r_count > c_z_end);
        r_count    <= (r_count > c_z_end) ? c_x_next : c_z_next;
      end else begin
        r_count <= r_count + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soc         <= 1'b0;
      data        <= 1'b0;
      data_valid  <= 1'b0;
      eoc         <= 1'b0;
      error       <= 1'b0;
      last_rx_bit <= 1'b0;
    end else begin
      soc        <= w_soc_nxt;
      data       <= w_data_nxt;
      data_valid <= w_dv_nxt;
      eoc        <= w_eoc_nxt;
      error      <= w_err_nxt;
      if (w_dv_nxt) last_rx_bit <= r_pend_bit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_miller_decode.sv
`default_nettype none
// tb_miller_decode : scoreboard bench, directed frames plus jittered random frames.
module tb_miller_decode;

  localparam int K_SOC  = 0;
  localparam int K_DATA = 1;
  localparam int K_EOC  = 2;
  localparam int K_ERR  = 3;
  localparam int PRE    = 40;

  typedef struct {
    int kind;
    int bitv;
    int rel;
    int lrx;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pin   = 1'b1;
  logic soc, data, data_valid, eoc, error, last_rx_bit;

  exp_t exp_q[$];
  int   rise_q[$];
  bit   wave[];
  int   cyc = 0;
  int   t0 = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_last = 0;
  bit   final_req = 1'b0;
  bit   final_done = 1'b0;

  miller_decode #(.Z_WIN_END(47), .X_WIN_END(111)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pause_n_synchronised (pin),
    .soc                  (soc),
    .data                 (data),
    .data_valid           (data_valid),
    .eoc                  (eoc),
    .error                (error),
    .last_rx_bit          (last_rx_bit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse is matched against the head of the expected queue.
  always @(negedge clk) begin
    int   kind;
    int   nact;
    exp_t e;
    if (!rst_n) begin
      n_cmp++;
      if ({soc, data, data_valid, eoc, error, last_rx_bit} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_outputs: got %b want 000000 at cycle %0d",
                 {soc, data, data_valid, eoc, error, last_rx_bit}, cyc);
      end
    end else begin
      nact = int'(soc) + int'(data_valid) + int'(eoc) + int'(error);
      if (nact > 0) begin
        kind = soc ? K_SOC : data_valid ? K_DATA : eoc ? K_EOC : K_ERR;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: got kind %0d data %0d at rel %0d, want no pulse",
                   kind, data, cyc - t0);
        end else begin
          e = exp_q.pop_front();
          if (nact > 1 || kind != e.kind ||
              (kind == K_DATA && int'(data) != e.bitv) ||
              (e.rel >= 0 && (cyc - t0) != e.rel) ||
              (e.lrx >= 0 && int'(last_rx_bit) != e.lrx)) begin
            n_bad++;
            $display("FAIL event: got kind %0d (pulses %0d) data %0d rel %0d lrx %0d, want kind %0d data %0d rel %0d lrx %0d",
                     kind, nact, data, cyc - t0, last_rx_bit, e.kind, e.bitv, e.rel, e.lrx);
          end
        end
      end
    end
    if (final_req && !final_done) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain: got %0d expected events never seen, want 0", exp_q.size());
      end
      final_done = 1'b1;
    end
  end

  task automatic exp_push(input int kind, input int bitv, input int rel, input int lrx);
    exp_t e;
    e.kind = kind;
    e.bitv = bitv;
    e.rel  = rel;
    e.lrx  = lrx;
    exp_q.push_back(e);
  endtask

  task automatic set_rises(input int a, input int b, input int c);
    rise_q.delete();
    rise_q.push_back(a);
    if (b >= 0) rise_q.push_back(b);
    if (c >= 0) rise_q.push_back(c);
  endtask

  // Each rise is preceded by plen low cycles; rel 0 is the SOC rise cycle.
  task automatic play(input int plen, input int rel_end);
    int n;
    n = rel_end + PRE;
    wave = new[n];
    foreach (wave[i]) wave[i] = 1'b1;
    foreach (rise_q[k])
      for (int c = rise_q[k] - plen; c < rise_q[k]; c++)
        if (c + PRE >= 0 && c + PRE < n) wave[c + PRE] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      pin = wave[i];
      if (i == PRE) t0 = cyc;
    end
  endtask

  // Miller encoding: 1 -> X (mid-bit pause), 0 after 0 -> Z (early pause), 0 after 1 -> Y.
  task automatic encode(input int k, input int b, input int prev);
    int jit;
    jit = int'($urandom_range(16, 0)) - 8;
    if (b != 0)         rise_q.push_back(128 * k + 64 + jit);
    else if (prev == 0) rise_q.push_back(128 * k + jit);
  endtask

  task automatic rand_frame(input int nbits);
    int prev;
    int b;
    prev = 0;
    b = 0;
    rise_q.delete();
    rise_q.push_back(0);
    exp_push(K_SOC, 0, 1, -1);
    for (int k = 1; k <= nbits; k++) begin
      b = int'($urandom_range(1, 0));
      encode(k, b, prev);
      exp_push(K_DATA, b, -1, b);
      prev = b;
    end
    encode(nbits + 1, 0, prev);
    exp_push(K_EOC, 0, -1, prev);
    model_last = prev;
    play(int'($urandom_range(30, 12)), 128 * (nbits + 3) + 32);
  endtask

  task automatic frame_one();
    set_rises(0, 192, -1);
    exp_push(K_SOC, 0, 1, -1);
    exp_push(K_DATA, 1, 368, 1);
    exp_push(K_EOC, 0, 496, 1);
    model_last = 1;
    play(16, 600);
  endtask

  task automatic frame_zero();
    set_rises(0, 128, 256);
    exp_push(K_SOC, 0, 1, -1);
    exp_push(K_DATA, 0, 368, 0);
    exp_push(K_EOC, 0, 496, 0);
    model_last = 0;
    play(16, 600);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    frame_one();

    // Z after X is a coding violation
    set_rises(0, 192, 256);
    exp_push(K_SOC, 0, 1, -1);
    exp_push(K_ERR, 0, 368, model_last);
    play(16, 600);

    frame_zero();

    // Rise beyond the X window
    set_rises(0, 232, -1);
    exp_push(K_SOC, 0, 1, -1);
    exp_push(K_ERR, 0, 233, model_last);
    play(16, 500);

    // Two rises in one window
    set_rises(0, 130, 140);
    exp_push(K_SOC, 0, 1, -1);
    exp_push(K_ERR, 0, 141, model_last);
    play(8, 400);

    // Rise on the window-end cycle opens the next window as Z
    set_rises(0, 111, 239);
    exp_push(K_SOC, 0, 1, -1);
    exp_push(K_DATA, 0, 351, 0);
    exp_push(K_EOC, 0, 479, 0);
    model_last = 0;
    play(16, 600);

    frame_one();

    // Reset between data bits: frame aborted silently
    set_rises(0, 192, 320);
    exp_push(K_SOC, 0, 1, -1);
    play(16, 300);
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_last = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    frame_zero();
    frame_one();

    for (int f = 0; f < 25; f++) rand_frame(int'($urandom_range(10, 1)));
    rand_frame(64);

    repeat (20) @(posedge clk);
    final_req = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
    if (!final_done) begin
      $display("FAIL final_check: monitor did not complete");
      $fatal(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
